text_buffer_ctrl: RTL and testbench
===================================

# text_buffer_ctrl

Write-side controller for the typewriter's 64×8 character RAM (single write port, registered read port). It accepts decoded ASCII key events over a valid/ready handshake and keeps a 6-bit cursor. It turns printable, backspace and enter codes into RAM write cycles and blanks the whole buffer with spaces after reset or on request. The display path keeps driving the RAM read port directly; this block owns the write port only.

## Interface
Parameters:
- `BLANK`, default 8'h20, fill character used for clear and backspace.
- `ROW_LEN`, default 16, characters per row; power of two dividing 64. Rows are 64/ROW_LEN.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `key_data`  in  8  ASCII code of the key event.
- `key_valid`  in  1  key event present; held until accepted.
- `key_ready`  out  1  combinational; high when an event can be accepted this cycle.
- `clear_req`  in  1  single-cycle pulse (or level) requesting a buffer blank.
- `busy`  out  1  high while the clear sequence runs.
- `cursor`  out  6  current cursor address.
- `ram_we`  out  1  RAM write enable, registered.
- `ram_write_address`  out  6  RAM write address, registered.
- `ram_d`  out  8  RAM write data, registered.

## Operation
- FSM states: CLEAR and IDLE.
- In CLEAR, a 6-bit `clr_cnt` issues writes of BLANK to addresses 0..63, one per cycle. After the write to 63 is issued, the FSM goes to IDLE and the cursor is 0.
- `reset` forces CLEAR with `clr_cnt`=0. Reset values: `ram_we`=0, `ram_write_address`=0, `ram_d`=0, `cursor`=0, `busy`=1, `key_ready`=0.
- A reset asserted mid-clear restarts the clear from address 0.
- `key_ready` = (state==IDLE) && !`clear_req`.
- In IDLE, `clear_req` high moves the FSM to CLEAR. Clear wins over a simultaneous `key_valid`, and that key stays pending.
- An event is accepted on a posedge where `key_valid` && `key_ready`. Handling by code:
  - 0x20–0x7E (printable): write `key_data` at `cursor`, then cursor+1.
  - 0x08 (backspace): if cursor>0, write BLANK at cursor−1 and set cursor to cursor−1. At cursor 0 the event is consumed and nothing changes.
  - 0x0D (enter): move cursor to the start of the next row, ((cursor/ROW_LEN)+1)·ROW_LEN. No write.
  - Any other code: consumed and ignored. No write, no cursor change.
- End of buffer: the behaviour at cursor 63 and on enter in the last row is set by the macro in Configuration.
- `ram_we` is low in every cycle with no accepted write.

## Timing
- Accept at edge N drives `ram_we`/`ram_write_address`/`ram_d` during cycle N→N+1, so the RAM stores the value at edge N+1.
- `cursor` updates at edge N.
- Back-to-back accepts are allowed every cycle, giving full throughput of one key per clock.
- Clear takes 64 write cycles. `busy` falls on the edge that issues the address-63 write, and `key_ready` can be high in the next cycle.
- The display sees the new data at the RAM's own read latency (one cycle) after the write edge.
- `key_ready` is never high while `busy` is high.

## Configuration
- `TEXT_BUFFER_WRAP_EN` defined:
  - A printable at cursor 63 writes, then the cursor wraps to 0.
  - Enter in the last row sets cursor to 0.
- `TEXT_BUFFER_WRAP_EN` undefined:
  - A printable at cursor 63 writes at 63 and the cursor stays at 63, so later printables overwrite cell 63.
  - Enter in the last row leaves the cursor unchanged.

## Test plan
- Reset release → `busy`=1 for 64 cycles, with writes of 0x20 to addresses 0..63 in order, then `busy`=0, `cursor`=0 and `key_ready`=1.
- Keys 'H','i' on consecutive cycles → writes (0,0x48) then (1,0x69) on consecutive cycles; cursor=2.
- At cursor=2, send 0x08 → write (1,0x20), cursor=1. Reset, send 0x08 at cursor=0 → no write, cursor=0, event accepted.
- At cursor=5, send 0x0D → no write, cursor=16. Repeat three more times:
  - WRAP_EN undefined: cursor ends at 48.
  - WRAP_EN defined: cursor ends at 0.
- Fill to cursor 63, send 'A' then 'B':
  - WRAP_EN defined: writes (63,0x41), (0,0x42); cursor=1.
  - WRAP_EN undefined: writes (63,0x41), (63,0x42); cursor=63.
- `clear_req` together with `key_valid`='X' → key not accepted and clear runs 64 cycles. Then 'X' is accepted: write (0,0x58). Also assert `reset` at clear address 30 → the clear restarts at address 0.

Source files
------------

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: write-side controller for a 64x8 character RAM; TEXT_BUFFER_WRAP_EN enables cursor wrap at end of buffer.
module text_buffer_ctrl #(
  parameter logic [7:0] BLANK = 8'h20,
  parameter int ROW_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       clear_req,
  output logic       busy,
  output logic [5:0] cursor,
  output logic       ram_we,
  output logic [5:0] ram_write_address,
  output logic [7:0] ram_d
);
`ifdef TEXT_BUFFER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  // ROW_LEN is a power of two, so 64-ROW_LEN is exactly the mask of the row bits
  localparam logic [5:0] ROW_MASK = 6'(64 - ROW_LEN);
  localparam logic [5:0] ROW_STEP = 6'(ROW_LEN);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [5:0] clr_cnt, clr_cnt_n, cursor_n, wa_n, row_start;
  logic [7:0] d_n;
  logic       we_n, printable, last_row;
  assign key_ready = (state == IDLE) && !clear_req;
  assign busy = (state == CLEAR);
  assign printable = (key_data >= 8'h20) && (key_data <= 8'h7E);
  assign row_start = cursor & ROW_MASK;
  assign last_row = (row_start == ROW_MASK);
  always_comb begin
    state_n = state;
    clr_cnt_n = clr_cnt;
    cursor_n = cursor;
    we_n = 1'b0;
    wa_n = ram_write_address;
    d_n = ram_d;
    if (state == CLEAR) begin
      we_n = 1'b1;
      wa_n = clr_cnt;
      d_n = BLANK;
      clr_cnt_n = clr_cnt + 6'd1;
      if (clr_cnt == 6'd63) begin
        state_n = IDLE;
        cursor_n = 6'd0;
      end
    end else if (clear_req) begin
      state_n = CLEAR;
      clr_cnt_n = 6'd0;
    end else if (key_valid) begin
      if (printable) begin
        we_n = 1'b1;
        wa_n = cursor;
        d_n = key_data;
        cursor_n = (cursor == 6'd63 && !WRAP) ? cursor : cursor + 6'd1;
      end else if (key_data == 8'h08 && cursor != 6'd0) begin
        we_n = 1'b1;
        wa_n = cursor - 6'd1;
        d_n = BLANK;
        cursor_n = cursor - 6'd1;
      end else if (key_data == 8'h0D) begin
        cursor_n = (last_row && !WRAP) ? cursor : row_start + ROW_STEP;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      clr_cnt <= 6'd0;
      cursor <= 6'd0;
      ram_we <= 1'b0;
      ram_write_address <= 6'd0;
      ram_d <= 8'd0;
    end else begin
      state <= state_n;
      clr_cnt <= clr_cnt_n;
      cursor <= cursor_n;
      ram_we <= we_n;
      ram_write_address <= wa_n;
      ram_d <= d_n;
    end
  end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: scoreboard bench for text_buffer_ctrl; honours TEXT_BUFFER_WRAP_EN.
module tb_text_buffer_ctrl;
`ifdef TEXT_BUFFER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int ROW_LEN = 16;
  logic clk = 0, reset = 0, key_valid = 0, clear_req = 0, key_ready, busy, ram_we;
  logic [7:0] key_data = 0, ram_d;
  logic [5:0] cursor, ram_write_address;
  int errors = 0, checks = 0, cur = 0;
  logic [13:0] exp_q[$];
  text_buffer_ctrl #(.BLANK(8'h20), .ROW_LEN(ROW_LEN)) dut (
    .clk(clk), .reset(reset), .key_data(key_data), .key_valid(key_valid),
    .key_ready(key_ready), .clear_req(clear_req), .busy(busy), .cursor(cursor),
    .ram_we(ram_we), .ram_write_address(ram_write_address), .ram_d(ram_d)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (ram_we) begin
      if (exp_q.size() == 0) chk("unexpected_write_addr", int'(ram_write_address), -1);
      else begin
        logic [13:0] e;
        e = exp_q.pop_front();
        chk("write_addr", int'(ram_write_address), int'(e[13:8]));
        chk("write_data", int'(ram_d), int'(e[7:0]));
      end
    end
  end
  function automatic void push_clear();
    for (int a = 0; a < 64; a++) exp_q.push_back({6'(a), 8'h20});
    cur = 0;
  endfunction
  function automatic void model(input logic [7:0] d);
    int r;
    if (d >= 8'h20 && d <= 8'h7E) begin
      exp_q.push_back({6'(cur), d});
      cur = (cur == 63) ? (WRAP ? 0 : 63) : cur + 1;
    end else if (d == 8'h08) begin
      if (cur > 0) begin
        cur--;
        exp_q.push_back({6'(cur), 8'h20});
      end
    end else if (d == 8'h0D) begin
      r = (cur / ROW_LEN + 1) * ROW_LEN;
      cur = (r >= 64) ? (WRAP ? 0 : cur) : r;
    end
  endfunction
  task automatic do_reset();
    int n;
    key_valid = 0;
    clear_req = 0;
    reset = 1;
    @(posedge clk);
    #1;
    exp_q.delete();
    push_clear();
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_key_ready", int'(key_ready), 0);
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_ram_d", int'(ram_d), 0);
    reset = 0;
    for (n = 1; n < 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy) break;
    end
    chk("clear_cycles", n, 64);
    chk("post_clear_ready", int'(key_ready), 1);
    chk("post_clear_cursor", int'(cursor), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, output int waited);
    waited = 0;
    key_data = d;
    key_valid = 1;
    @(negedge clk);
    while (!key_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!key_ready) chk("key_ready_timeout", 0, 1);
    model(d);
    @(posedge clk);
    #1;
    key_valid = 0;
    chk("cursor", int'(cursor), cur);
  endtask
  initial begin
    int w;
    logic [7:0] k;
    do_reset();
    send("H", w);
    send("i", w);
    chk("hi_cursor", int'(cursor), 2);
    send(8'h08, w);
    chk("bs_cursor", int'(cursor), 1);
    do_reset();
    send(8'h08, w);
    chk("bs_zero_cursor", int'(cursor), 0);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), w);
    send(8'h0D, w);
    chk("enter_cursor", int'(cursor), 16);
    for (int i = 0; i < 3; i++) send(8'h0D, w);
    chk("enter_last_row", int'(cursor), WRAP ? 0 : 48);
    do_reset();
    for (int i = 0; i < 63; i++) send(8'h30 + 8'(i % 10), w);
    chk("fill_cursor", int'(cursor), 63);
    send("A", w);
    send("B", w);
    chk("end_cursor", int'(cursor), WRAP ? 1 : 63);
    key_data = "X";
    key_valid = 1;
    clear_req = 1;
    @(negedge clk);
    chk("clear_blocks_ready", int'(key_ready), 0);
    @(posedge clk);
    #1;
    clear_req = 0;
    push_clear();
    send("X", w);
    chk("clear_wait", w, 64);
    chk("x_cursor", int'(cursor), 1);
    clear_req = 1;
    @(posedge clk);
    #1;
    clear_req = 0;
    push_clear();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(ram_we && ram_write_address == 6'd30) && w < 200);
    chk("reach_addr30", int'(ram_write_address), 30);
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: k = 8'h08;
        1: k = 8'h0D;
        2: k = 8'($urandom_range(0, 31));
        3: k = 8'($urandom_range(127, 255));
        default: k = 8'($urandom_range(32, 126));
      endcase
      send(k, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
